frv_pipeline_writeback: RTL
===========================

// Module: frv_pipeline_writeback
// PURPOSE
//  Final backend stage. Accepts retiring instructions from the execute/memory
//  stage and waits for data memory load responses. Performs load byte/half
//  extraction and sign extension. Drives the GPR write port and the s4
//  forwarding/hazard signals consumed by dispatch. Raises traps and retires
//  instructions.
// PARAMETERS
//  XLEN       32   datapath width; XL = XLEN-1
//  LD_FAULT   5    trap cause reported on a load response error
// PORTS
//  g_clk           in   1    clock
//  g_resetn        in   1    asynchronous active-low reset
//  s4_p_valid      in   1    input instruction valid
//  s4_p_busy       out  1    stage cannot accept input this cycle
//  s4_rd           in   5    destination reg; trap cause when s4_trap=1
//  s4_wdata        in   XL+1 result for non-load instructions
//  s4_pc           in   32   program counter
//  s4_load         in   1    instruction is a load
//  s4_csr          in   1    instruction is a CSR op
//  s4_ld_size      in   2    00 byte, 01 half, 10 word
//  s4_ld_signed    in   1    sign-extend load data
//  s4_addr_lo      in   2    load address bits [1:0]
//  s4_trap         in   1    instruction raises trap
//  flush           in   1    discard held instruction
//  dmem_rsp_valid  in   1    load response valid
//  dmem_rsp_rdata  in   32   load response word
//  dmem_rsp_error  in   1    load response bus error
//  dmem_rsp_ready  out  1    response accepted when valid&&ready
//  gpr_wen/gpr_rd/gpr_wdata  out 1/5/XL+1  GPR write port
//  fwd_s4_rd/fwd_s4_wdata    out 5/XL+1    forwarding dest/value
//  fwd_s4_load/fwd_s4_csr    out 1/1       forward value not usable / CSR
//  trap_valid/trap_cause/trap_pc out 1/5/32  trap report, one cycle
//  instr_ret       out  1    instruction retired, one-cycle pulse
// BEHAVIOUR
//  - States: EMPTY, COMMIT, WAIT_LD, TRAP, DRAIN. Reset -> EMPTY; all outputs 0.
//  - Accept when s4_p_valid && !s4_p_busy. s4_p_busy=1 in WAIT_LD, DRAIN, TRAP.
//    Otherwise s4_p_busy=0.
//  - On accept, the held registers capture rd, wdata, pc, csr, ld_size,
//    ld_signed and addr_lo. The next state is TRAP if s4_trap, WAIT_LD if
//    s4_load, else COMMIT.
//  - COMMIT lasts one cycle. gpr_wen = (held rd != 0). instr_ret=1.
//    In the same cycle, a new accept is allowed, giving 1 instr/cycle.
//    If no new accept, the next state is EMPTY.
//  - WAIT_LD: dmem_rsp_ready=1.
//    - rsp_valid && !error: capture the extracted data into held wdata; go COMMIT.
//      A response in cycle N gives gpr_wen in cycle N+1.
//    - rsp_valid && error: go TRAP with cause LD_FAULT.
//  - Extraction: byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16];
//    word = rdata. Zero- or sign-extend to XLEN per ld_signed.
//    Misalignment is excluded upstream.
//  - TRAP lasts one cycle. trap_valid=1, trap_cause = held rd (or LD_FAULT),
//    trap_pc = held pc. No GPR write, no instr_ret. Next state EMPTY.
//  - fwd_s4_rd = held rd in COMMIT or WAIT_LD, else 0.
//    fwd_s4_wdata = held wdata. fwd_s4_csr = held csr in COMMIT only.
//    fwd_s4_load = 1 in WAIT_LD: the forwarded value is not yet valid and
//    consumers stall.
//  - flush: COMMIT/TRAP -> EMPTY, no write, no trap. WAIT_LD -> DRAIN, or
//    -> EMPTY if the response arrives in the same cycle; that response is
//    discarded. flush takes priority over a same-cycle accept.
//  - DRAIN: dmem_rsp_ready=1. The next response is discarded regardless of
//    error; then go EMPTY. flush in DRAIN has no extra effect.
//  - Async reset mid-WAIT_LD or DRAIN -> EMPTY. The outstanding response is
//    owned by the memory interface reset.
// TESTING
//  - ALU ops rd=3,4,5 on back-to-back cycles -> gpr_wen 3 consecutive cycles,
//    3 instr_ret, s4_p_busy stays 0.
//  - lb signed, addr_lo=2, rsp 0x00800000 after 3 cycles -> busy 4 cycles,
//    gpr_wdata=0xFFFFFF80 one cycle after rsp; lbu -> 0x00000080.
//  - lh signed, addr_lo=2, rsp 0x8001_1234 -> 0xFFFF8001; rd=0 -> gpr_wen
//    stays 0 but instr_ret=1.
//  - load with rsp error -> trap_valid=1, trap_cause=5, trap_pc=held pc,
//    no gpr_wen, no instr_ret.
//  - flush in WAIT_LD, rsp 3 cycles later -> no write/trap, busy until
//    rsp consumed, then accept next.
//  - reset asserted in WAIT_LD -> all outputs 0 immediately, EMPTY.
//    CSR in COMMIT -> fwd_s4_csr=1 for one cycle.

Source files
------------

// File: rtl/frv_pipeline_writeback.sv
// ----------------------------------------------------------------------------
// frv_pipeline_writeback
//
// Final backend stage of the pipeline. Takes one retiring instruction at a
// time from execute/memory, waits for the data-memory response when that
// instruction is a load, extracts and extends the loaded byte/half/word,
// writes the GPR file, raises traps and pulses instr_ret on retirement. It
// also publishes the held destination register and value so dispatch can
// forward from this stage or stall on it.
//
// Ports
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   s4_p_valid / s4_p_busy     input handshake (accept = valid && !busy)
//   s4_rd                      destination register, or trap cause if s4_trap
//   s4_wdata, s4_pc            non-load result, program counter
//   s4_load, s4_csr, s4_trap   instruction class flags
//   s4_ld_size/_signed/addr_lo load size (00 B, 01 H, 10 W), signedness,
//                              low address bits used to select the lane
//   flush                      discard whatever this stage is holding
//   dmem_rsp_*                 load response channel (valid/ready/rdata/error)
//   gpr_wen/gpr_rd/gpr_wdata   GPR write port
//   fwd_s4_rd/_wdata/_load/_csr forwarding and hazard information
//   trap_valid/_cause/_pc      one-cycle trap report
//   instr_ret                  one-cycle retirement pulse
// ----------------------------------------------------------------------------
module frv_pipeline_writeback #(
  parameter int         XLEN     = 32,
  parameter logic [4:0] LD_FAULT = 5'd5
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            s4_p_valid,
  output logic            s4_p_busy,
  input  logic [4:0]      s4_rd,
  input  logic [XLEN-1:0] s4_wdata,
  input  logic [31:0]     s4_pc,
  input  logic            s4_load,
  input  logic            s4_csr,
  input  logic [1:0]      s4_ld_size,
  input  logic            s4_ld_signed,
  input  logic [1:0]      s4_addr_lo,
  input  logic            s4_trap,
  input  logic            flush,
  input  logic            dmem_rsp_valid,
  input  logic [31:0]     dmem_rsp_rdata,
  input  logic            dmem_rsp_error,
  output logic            dmem_rsp_ready,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic [4:0]      fwd_s4_rd,
  output logic [XLEN-1:0] fwd_s4_wdata,
  output logic            fwd_s4_load,
  output logic            fwd_s4_csr,
  output logic            trap_valid,
  output logic [4:0]      trap_cause,
  output logic [31:0]     trap_pc,
  output logic            instr_ret
);

  // --------------------------------------------------------------------------
  // State and held instruction
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_EMPTY,    // nothing held
    ST_COMMIT,   // held result is written back this cycle
    ST_WAIT_LD,  // load outstanding, waiting for the memory response
    ST_TRAP,     // held instruction reports its trap this cycle
    ST_DRAIN     // flushed load: swallow its response, then go empty
  } state_t;

  state_t          state;

  logic [4:0]      held_rd;        // destination, or trap cause in ST_TRAP
  logic [XLEN-1:0] held_wdata;
  logic [31:0]     held_pc;
  logic            held_csr;
  logic [1:0]      held_ld_size;
  logic            held_ld_signed;
  logic [1:0]      held_addr_lo;

  logic            accept;
  logic            rsp_fire;

  // The stage can take a new instruction whenever it is empty or finishing a
  // commit; that overlap is what gives one instruction per cycle.
  assign s4_p_busy      = (state == ST_WAIT_LD) || (state == ST_DRAIN) ||
                          (state == ST_TRAP);
  assign dmem_rsp_ready = (state == ST_WAIT_LD) || (state == ST_DRAIN);

  // flush wins over a same-cycle accept.
  assign accept   = s4_p_valid && !s4_p_busy && !flush;
  assign rsp_fire = dmem_rsp_valid && dmem_rsp_ready;

  // --------------------------------------------------------------------------
  // Load data extraction
  // --------------------------------------------------------------------------
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statements can leave a value unassigned (latch).
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_data = '0;

    case (held_addr_lo)
      2'd0:    ld_byte = dmem_rsp_rdata[7:0];
      2'd1:    ld_byte = dmem_rsp_rdata[15:8];
      2'd2:    ld_byte = dmem_rsp_rdata[23:16];
      default: ld_byte = dmem_rsp_rdata[31:24];
    endcase

    // Halfword loads are aligned, so only addr_lo[1] picks the lane.
    ld_half = held_addr_lo[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];

    // A signed cast followed by a width cast sign-extends; the plain width
    // cast zero-extends.
    case (held_ld_size)
      2'b00: ld_data = held_ld_signed ? XLEN'(signed'(ld_byte)) : XLEN'(ld_byte);
      2'b01: ld_data = held_ld_signed ? XLEN'(signed'(ld_half)) : XLEN'(ld_half);
      default: ld_data = held_ld_signed ? XLEN'(signed'(dmem_rsp_rdata))
                                        : XLEN'(dmem_rsp_rdata);
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM and held registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state          <= ST_EMPTY;
      // NOTE: these are a handful of flops, not a memory array; resetting them
      // keeps every output that is read straight from them at 0 after reset.
      held_rd        <= '0;
      held_wdata     <= '0;
      held_pc        <= '0;
      held_csr       <= 1'b0;
      held_ld_size   <= '0;
      held_ld_signed <= 1'b0;
      held_addr_lo   <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_COMMIT: begin
          if (accept) begin
            held_rd        <= s4_rd;
            held_wdata     <= s4_wdata;
            held_pc        <= s4_pc;
            held_csr       <= s4_csr;
            held_ld_size   <= s4_ld_size;
            held_ld_signed <= s4_ld_signed;
            held_addr_lo   <= s4_addr_lo;
            if (s4_trap) begin
              state <= ST_TRAP;
            end else if (s4_load) begin
              state <= ST_WAIT_LD;
            end else begin
              state <= ST_COMMIT;
            end
          end else begin
            state <= ST_EMPTY;
          end
        end

        ST_WAIT_LD: begin
          if (flush) begin
            // A response landing in the flush cycle is consumed and dropped;
            // otherwise it is still owed and DRAIN swallows it.
            state <= rsp_fire ? ST_EMPTY : ST_DRAIN;
          end else if (rsp_fire) begin
            if (dmem_rsp_error) begin
              // The trap cause travels in held_rd; nothing is written back.
              held_rd <= LD_FAULT;
              state   <= ST_TRAP;
            end else begin
              held_wdata <= ld_data;
              state      <= ST_COMMIT;
            end
          end
        end

        ST_TRAP: begin
          state <= ST_EMPTY;
        end

        ST_DRAIN: begin
          if (rsp_fire) begin
            state <= ST_EMPTY;
          end
        end

        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from the state and held registers only, except that a
  // flush in the commit/trap cycle suppresses the architectural side effects.
  // --------------------------------------------------------------------------
  logic commit_live;
  logic trap_live;

  assign commit_live = (state == ST_COMMIT) && !flush;
  assign trap_live   = (state == ST_TRAP) && !flush;

  assign gpr_wen   = commit_live && (held_rd != 5'd0);
  assign gpr_rd    = held_rd;
  assign gpr_wdata = held_wdata;
  assign instr_ret = commit_live;

  assign trap_valid = trap_live;
  assign trap_cause = trap_live ? held_rd : 5'd0;
  assign trap_pc    = trap_live ? held_pc : 32'd0;

  // While a load is outstanding the destination is advertised with
  // fwd_s4_load set, telling dispatch to stall rather than forward.
  assign fwd_s4_rd    = ((state == ST_COMMIT) || (state == ST_WAIT_LD)) ? held_rd : 5'd0;
  assign fwd_s4_wdata = held_wdata;
  assign fwd_s4_load  = (state == ST_WAIT_LD);
  assign fwd_s4_csr   = (state == ST_COMMIT) && held_csr;

endmodule
